// File: rtl/fir_pkg.sv
// Shared types and widths for the FIR driver block.
package fir_pkg;
    localparam int SAMPLE_W = 8;
    localparam int RESULT_W = 16;
    localparam int IDX_W    = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } fir_state_e;
endpackage

// File: rtl/fir_res_fifo.sv
// Result FIFO: power-of-two depth, pointers wrap modulo depth, push and pop may coincide.
module fir_res_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push_s, do_pop_s;

    // A full FIFO still takes a push when the same cycle frees a slot.
    assign do_pop_s  = pop && (count_q != '0);
    assign do_push_s = push && ((count_q != FULL_CNT) || do_pop_s);

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_CNT);
    assign count     = count_q;
endmodule

// File: rtl/fir_driver.sv
// FIR driver: loads shadow coefficients, streams samples under credit, collects results.
// Optional checksum accumulator enabled by FIR_DRIVER_CHECKSUM_EN.
module fir_driver
    import fir_pkg::*;
#(
    parameter int NUM_TAPS       = 7,
    parameter int RES_FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] host_w_data,
    input  logic [IDX_W-1:0]    host_w_idx,
    input  logic                host_w_we,
    input  logic                start,
    input  logic [15:0]         run_len,
    input  logic [SAMPLE_W-1:0] smp_data,
    input  logic                smp_valid,
    output logic                smp_ready,
    output logic [SAMPLE_W-1:0] weight_data,
    output logic [IDX_W-1:0]    weight_idx,
    output logic                weight_valid,
    input  logic                weight_ready,
    output logic [SAMPLE_W-1:0] input_data,
    output logic                input_valid,
    input  logic                input_ready,
    input  logic [RESULT_W-1:0] output_data,
    input  logic                output_valid,
    output logic                output_ready,
    output logic [RESULT_W-1:0] res_data,
    output logic                res_valid,
    input  logic                res_ready,
    output logic                busy,
    output logic                done,
    output logic [15:0]         sample_count,
    output logic [23:0]         checksum
);
    localparam int CNT_W = $clog2(RES_FIFO_DEPTH) + 1;
    localparam logic [IDX_W:0]   NUM_TAPS_X = (IDX_W+1)'(NUM_TAPS);
    localparam logic [IDX_W-1:0] LAST_K     = IDX_W'(NUM_TAPS - 1);
    localparam logic [CNT_W:0]   DEPTH_X    = (CNT_W+1)'(RES_FIFO_DEPTH);

    fir_state_e         state_q, state_d;
    logic [IDX_W-1:0]   k_q, k_d;
    logic [15:0]        run_len_q, run_len_d;
    logic [15:0]        sample_count_q, sample_count_d;
    logic [CNT_W-1:0]   outstanding_q, outstanding_d;
    logic [SAMPLE_W-1:0] shadow_q [NUM_TAPS];
    logic [SAMPLE_W-1:0] shadow_d [NUM_TAPS];

    logic               in_stream_s, credit_s, in_hs_s, out_hs_s, pop_s, start_acc_s;
    logic               fifo_full_s, fifo_empty_s;
    logic [CNT_W-1:0]   fifo_count_s;
    logic [CNT_W:0]     inflight_s;

    assign in_stream_s  = (state_q == STREAM);
    assign inflight_s   = {1'b0, outstanding_q} + {1'b0, fifo_count_s};
    assign credit_s     = (inflight_s < DEPTH_X);
    assign input_valid  = in_stream_s & smp_valid & credit_s;
    assign smp_ready    = in_stream_s & input_ready & credit_s;
    assign input_data   = in_stream_s ? smp_data : '0;
    assign in_hs_s      = input_valid & input_ready;
    // Gated by rst so the capture side reads not-ready while reset is held.
    assign output_ready = rst & ~fifo_full_s;
    assign out_hs_s     = output_valid & output_ready;
    assign res_valid    = ~fifo_empty_s;
    assign pop_s        = res_valid & res_ready;
    assign start_acc_s  = (state_q == IDLE) & start;

    assign weight_valid = (state_q == LOAD_W);
    assign weight_idx   = weight_valid ? k_q : '0;
    assign weight_data  = weight_valid ? shadow_q[k_q] : '0;
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);
    assign sample_count = sample_count_q;

    // Sequencing, counters and shadow-file update.
    always_comb begin
        state_d        = state_q;
        k_d            = k_q;
        run_len_d      = run_len_q;
        sample_count_d = sample_count_q;
        shadow_d       = shadow_q;
        if (in_hs_s && !out_hs_s) begin
            outstanding_d = outstanding_q + CNT_W'(1);
        end else if (!in_hs_s && out_hs_s) begin
            outstanding_d = outstanding_q - CNT_W'(1);
        end else begin
            outstanding_d = outstanding_q;
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d        = LOAD_W;
                    k_d            = '0;
                    run_len_d      = run_len;
                    sample_count_d = 16'd0;
                    outstanding_d  = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD_W: begin
                if (weight_ready && (k_q == LAST_K)) begin
                    state_d = (run_len_q == 16'd0) ? DONE : STREAM;
                    k_d     = '0;
                end else if (weight_ready) begin
                    k_d = k_q + IDX_W'(1);
                end else begin
                    k_d = k_q;
                end
            end
            STREAM: begin
                if (in_hs_s) begin
                    sample_count_d = sample_count_q + 16'd1;
                    state_d = (sample_count_q + 16'd1 == run_len_q) ? DRAIN : STREAM;
                end else begin
                    state_d = STREAM;
                end
            end
            DRAIN: begin
                state_d = (outstanding_q == '0) ? DONE : DRAIN;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Taps already presented during a load are frozen so the beat stays stable.
        if (host_w_we && ({1'b0, host_w_idx} < NUM_TAPS_X) &&
            !((state_q == LOAD_W) && (host_w_idx <= k_q))) begin
            shadow_d[host_w_idx] = host_w_data;
        end else begin
            shadow_d = shadow_q;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            k_q            <= '0;
            run_len_q      <= 16'd0;
            sample_count_q <= 16'd0;
            outstanding_q  <= '0;
            for (int i = 0; i < NUM_TAPS; i++) shadow_q[i] <= '0;
        end else begin
            state_q        <= state_d;
            k_q            <= k_d;
            run_len_q      <= run_len_d;
            sample_count_q <= sample_count_d;
            outstanding_q  <= outstanding_d;
            shadow_q       <= shadow_d;
        end
    end

    fir_res_fifo #(
        .DEPTH (RES_FIFO_DEPTH),
        .W     (RESULT_W)
    ) u_res_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (out_hs_s),
        .push_data (output_data),
        .pop       (pop_s),
        .head_data (res_data),
        .empty     (fifo_empty_s),
        .full      (fifo_full_s),
        .count     (fifo_count_s)
    );

`ifdef FIR_DRIVER_CHECKSUM_EN
    logic [23:0] checksum_q, checksum_d;

    // Running sum of popped results, restarted by an accepted start.
    always_comb begin
        checksum_d = start_acc_s ? 24'd0 : checksum_q;
        if (pop_s) begin
            checksum_d = checksum_d + {8'd0, res_data};
        end else begin
            checksum_d = checksum_d;
        end
    end

    // Checksum register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            checksum_q <= 24'd0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    logic unused_start_acc_s;
    assign unused_start_acc_s = start_acc_s;
    assign checksum = 24'd0;
`endif
endmodule

// File: tb/tb_fir_driver.sv
// Scoreboard bench for fir_driver with a latency-2 filter model on the initiator ports.
module tb_fir_driver;
    import fir_pkg::*;
    localparam int NT = 7;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  host_w_data = 8'd0;
    logic [2:0]  host_w_idx = 3'd0;
    logic        host_w_we = 1'b0;
    logic        start = 1'b0;
    logic [15:0] run_len = 16'd0;
    logic [7:0]  smp_data = 8'd0;
    logic        smp_valid = 1'b0;
    logic        smp_ready;
    logic [7:0]  weight_data;
    logic [2:0]  weight_idx;
    logic        weight_valid;
    logic        weight_ready = 1'b1;
    logic [7:0]  input_data;
    logic        input_valid;
    logic        input_ready = 1'b1;
    logic [15:0] output_data = 16'd0;
    logic        output_valid = 1'b0;
    logic        output_ready;
    logic [15:0] res_data;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic        busy, done;
    logic [15:0] sample_count;
    logic [23:0] checksum;

    fir_driver dut (
        .clk(clk), .rst(rst),
        .host_w_data(host_w_data), .host_w_idx(host_w_idx), .host_w_we(host_w_we),
        .start(start), .run_len(run_len),
        .smp_data(smp_data), .smp_valid(smp_valid), .smp_ready(smp_ready),
        .weight_data(weight_data), .weight_idx(weight_idx),
        .weight_valid(weight_valid), .weight_ready(weight_ready),
        .input_data(input_data), .input_valid(input_valid), .input_ready(input_ready),
        .output_data(output_data), .output_valid(output_valid), .output_ready(output_ready),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .busy(busy), .done(done), .sample_count(sample_count), .checksum(checksum)
    );

    always #5 clk = ~clk;

    typedef struct { logic [15:0] d; int rdy; } pipe_t;
    pipe_t       pipe_q[$];
    logic [7:0]  smp_q[$];
    logic [15:0] exp_q[$];
    logic [7:0]  ref_w [NT];
    logic [7:0]  cap_w [NT];
    int n_checks = 0, n_fail = 0;
    int cyc = 0, in_hs_cnt = 0, w_beats = 0, done_cnt = 0, rcv_cnt = 0;
    int stall_cnt = 0;
    bit stall_en = 1'b0, prev_stall = 1'b0;
    logic [7:0] prev_wd = 8'd0;
    logic [2:0] prev_wi = 3'd0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] filt(input logic [7:0] x, input logic [7:0] w0, input logic [7:0] w1);
        return ({8'h00, x} * {8'h00, w0}) + {w1, 8'h00};
    endfunction

    // Edge monitor: filter model intake, scoreboard, weight-port checks.
    always @(posedge clk) begin
        cyc++;
        if (input_valid && input_ready) begin
            in_hs_cnt++;
            pipe_q.push_back('{d: filt(input_data, cap_w[0], cap_w[1]), rdy: cyc + 2});
            exp_q.push_back(filt(smp_data, ref_w[0], ref_w[1]));
        end
        if (output_valid && output_ready) void'(pipe_q.pop_front());
        if (smp_valid && smp_ready) void'(smp_q.pop_front());
        if (prev_stall) begin
            check_eq("w_idx_stable", weight_idx, prev_wi);
            check_eq("w_data_stable", weight_data, prev_wd);
        end
        if (weight_valid && weight_ready) begin
            check_eq("w_order", weight_idx, w_beats % NT);
            check_eq("w_data", weight_data, ref_w[w_beats % NT]);
            cap_w[weight_idx] = weight_data;
            w_beats++;
        end
        prev_stall = weight_valid && !weight_ready;
        prev_wi = weight_idx;
        prev_wd = weight_data;
        if (done) done_cnt++;
        if (res_valid && res_ready) begin
            rcv_cnt++;
            if (exp_q.size() == 0) check_eq("res_extra", exp_q.size(), 1);
            else check_eq("res_data", res_data, exp_q.pop_front());
        end
    end

    // Off-edge drivers for filter outputs, sample source and weight backpressure.
    always @(negedge clk) begin
        if (pipe_q.size() > 0 && pipe_q[0].rdy <= cyc) begin
            output_valid = 1'b1; output_data = pipe_q[0].d;
        end else begin
            output_valid = 1'b0; output_data = 16'd0;
        end
        if (smp_q.size() > 0) begin
            smp_valid = 1'b1; smp_data = smp_q[0];
        end else begin
            smp_valid = 1'b0; smp_data = 8'd0;
        end
        if (stall_en && weight_valid && weight_idx == 3'd3 && stall_cnt < 10) begin
            weight_ready = 1'b0; stall_cnt++;
        end else begin
            weight_ready = 1'b1;
        end
    end

    task automatic write_shadow(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] wr);
        for (int i = 0; i < NT; i++) begin
            @(negedge clk);
            host_w_we = 1'b1; host_w_idx = 3'(i);
            host_w_data = (i == 0) ? w0 : (i == 1) ? w1 : wr + 8'(i);
            ref_w[i] = host_w_data;
        end
        @(negedge clk);
        host_w_we = 1'b0;
    endtask

    task automatic start_run(input logic [15:0] len);
        w_beats = 0; in_hs_cnt = 0;
        @(negedge clk); start = 1'b1; run_len = len;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done_cnt != d0) break;
            @(negedge clk);
        end
        repeat (8) @(negedge clk);
        check_eq(tag, done_cnt - d0, 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_smp_ready"}, smp_ready, 0);
        check_eq({tag, "_weight_valid"}, weight_valid, 0);
        check_eq({tag, "_weight_data"}, {weight_idx, weight_data}, 0);
        check_eq({tag, "_input_valid"}, input_valid, 0);
        check_eq({tag, "_input_data"}, input_data, 0);
        check_eq({tag, "_output_ready"}, output_ready, 0);
        check_eq({tag, "_res_valid"}, res_valid, 0);
        check_eq({tag, "_res_data"}, res_data, 0);
        check_eq({tag, "_sample_count"}, sample_count, 0);
        check_eq({tag, "_checksum"}, checksum, 0);
    endtask

    initial begin
        int d0, r0;
        for (int i = 0; i < NT; i++) begin ref_w[i] = 8'd0; cap_w[i] = 8'd0; end
        repeat (3) @(negedge clk);
        check_outputs_zero("rst");
        rst = 1'b1;

        // Identity filter: 5,6,7 come back unchanged.
        write_shadow(8'd1, 8'd0, 8'd0 - 8'd2);
        for (int i = 2; i < NT; i++) ref_w[i] = 8'd0;
        for (int i = 2; i < NT; i++) begin
            @(negedge clk); host_w_we = 1'b1; host_w_idx = 3'(i); host_w_data = 8'd0;
        end
        @(negedge clk); host_w_we = 1'b0;
        smp_q.push_back(8'd5); smp_q.push_back(8'd6); smp_q.push_back(8'd7);
        d0 = done_cnt; r0 = rcv_cnt;
        start_run(16'd3);
        check_eq("t1_busy", busy, 1);
        wait_done("t1_done_once", d0, 200);
        check_eq("t1_sample_count", sample_count, 3);
        check_eq("t1_in_hs", in_hs_cnt, 3);
        check_eq("t1_w_beats", w_beats, 7);
        check_eq("t1_rcv", rcv_cnt - r0, 3);
        check_eq("t1_busy_end", busy, 0);

        // Weight backpressure on tap 3.
        write_shadow(8'h11, 8'h22, 8'h30);
        stall_en = 1'b1; stall_cnt = 0;
        smp_q.push_back(8'd2); smp_q.push_back(8'd3);
        d0 = done_cnt; r0 = rcv_cnt;
        start_run(16'd2);
        wait_done("t2_done_once", d0, 200);
        stall_en = 1'b0;
        check_eq("t2_stall_cycles", stall_cnt, 10);
        check_eq("t2_w_beats", w_beats, 7);
        check_eq("t2_rcv", rcv_cnt - r0, 2);

        // Result backpressure limits issue to the FIFO depth.
        write_shadow(8'd1, 8'd0, 8'd0 - 8'd2);
        for (int i = 2; i < NT; i++) begin
            @(negedge clk); host_w_we = 1'b1; host_w_idx = 3'(i); host_w_data = 8'd0; ref_w[i] = 8'd0;
        end
        @(negedge clk); host_w_we = 1'b0;
        res_ready = 1'b0;
        for (int i = 0; i < 8; i++) smp_q.push_back(8'h20 + 8'(i));
        d0 = done_cnt; r0 = rcv_cnt;
        start_run(16'd8);
        repeat (40) @(negedge clk);
        check_eq("t3_in_hs_capped", in_hs_cnt, 4);
        check_eq("t3_res_valid", res_valid, 1);
        check_eq("t3_output_ready_full", output_ready, 0);
        check_eq("t3_busy", busy, 1);
        res_ready = 1'b1;
        wait_done("t3_done_once", d0, 300);
        check_eq("t3_rcv", rcv_cnt - r0, 8);
        check_eq("t3_scoreboard_empty", exp_q.size(), 0);
        check_eq("t3_model_empty", pipe_q.size(), 0);

        // Zero-length run: weights only.
        d0 = done_cnt;
        start_run(16'd0);
        wait_done("t4_done_once", d0, 100);
        check_eq("t4_w_beats", w_beats, 7);
        check_eq("t4_in_hs", in_hs_cnt, 0);
        check_eq("t4_sample_count", sample_count, 0);

        // Reset in the middle of a run.
        for (int i = 0; i < 5; i++) smp_q.push_back(8'h40 + 8'(i));
        d0 = done_cnt;
        start_run(16'd5);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (in_hs_cnt == 2) break;
        end
        check_eq("t5_in_hs_before_rst", in_hs_cnt, 2);
        #1 rst = 1'b0;
        #1 check_outputs_zero("t5_abort");
        smp_q.delete(); pipe_q.delete(); exp_q.delete();
        for (int i = 0; i < NT; i++) ref_w[i] = 8'd0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("t5_no_done", done_cnt - d0, 0);
        check_eq("t5_busy_after", busy, 0);

        // After reset the shadow file reads back as zeros.
        d0 = done_cnt;
        start_run(16'd0);
        wait_done("t5b_done_once", d0, 100);
        check_eq("t5b_w_beats", w_beats, 7);

`ifdef FIR_DRIVER_CHECKSUM_EN
        write_shadow(8'd1, 8'hFF, 8'd0 - 8'd2);
        for (int i = 0; i < 300; i++) smp_q.push_back(8'hFF);
        d0 = done_cnt; r0 = rcv_cnt;
        start_run(16'd300);
        wait_done("t6_done_once", d0, 4000);
        check_eq("t6_rcv", rcv_cnt - r0, 300);
        check_eq("t6_checksum", checksum, 24'h2BFED4);
`else
        check_eq("t6_checksum_tied", checksum, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fir_driver.md
FIR_DRIVER -- requirements
Module: fir_driver

Interface
REQ-001 SHALL have parameter NUM_TAPS, default 7, number of coefficients loaded per run.
REQ-002 SHALL have parameter RES_FIFO_DEPTH, default 4, result FIFO entries (power of two, >= 2).
REQ-003 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports host_w_data input 8, host_w_idx input 3, host_w_we input 1: host write into shadow coefficient file.
REQ-006 SHALL have ports start input 1 (run request pulse) and run_len input 16 (samples per run, sampled on accepted start).
REQ-007 SHALL have ports smp_data input 8, smp_valid input 1, smp_ready output 1: upstream sample stream.
REQ-008 SHALL have ports weight_data output 8, weight_idx output 3, weight_valid output 1, weight_ready input 1: coefficient load, initiator side.
REQ-009 SHALL have ports input_data output 8, input_valid output 1, input_ready input 1: sample issue, initiator side.
REQ-010 SHALL have ports output_data input 16, output_valid input 1, output_ready output 1: filter result capture.
REQ-011 SHALL have ports res_data output 16, res_valid output 1, res_ready input 1: downstream result stream.
REQ-012 SHALL have ports busy output 1, done output 1 (one-cycle pulse), sample_count output 16, checksum output 24.

Function
REQ-013 SHALL implement states IDLE, LOAD_W, STREAM, DRAIN, DONE.
REQ-014 SHALL leave IDLE for LOAD_W on start=1; start outside IDLE is ignored.
REQ-015 SHALL in LOAD_W present shadow[k] with weight_idx=k, weight_valid=1, advancing k on weight_valid&weight_ready; after k=NUM_TAPS-1 handshake go to STREAM, or DONE if run_len=0.
REQ-016 SHALL in STREAM pass smp_data to input_data combinationally; input_valid=smp_valid&credit, smp_ready=input_ready&credit; smp_ready=0 outside STREAM.
REQ-017 SHALL define credit = (outstanding + fifo_count) < RES_FIFO_DEPTH; outstanding increments per input handshake, decrements per output_valid&output_ready, simultaneous events net zero.
REQ-018 SHALL increment sample_count per input handshake and go to DRAIN on the handshake making sample_count equal run_len.
REQ-019 SHALL drive output_ready=1 whenever result FIFO not full; output beats push output_data into FIFO.
REQ-020 SHALL go DRAIN -> DONE when outstanding=0; DONE lasts one cycle with done=1, then IDLE.
REQ-021 SHALL present FIFO head on res_data with res_valid=!empty; pop on res_valid&res_ready; simultaneous push and pop when full or empty are both honoured; FIFO pointers wrap modulo depth.
REQ-022 SHALL assert busy in every state except IDLE; FIFO keeps draining in IDLE.
REQ-023 SHALL accept host_w_we writes in any state, but writes in LOAD_W affect only taps not yet issued; idx >= NUM_TAPS ignored.
REQ-024 SHALL clear sample_count and outstanding on accepted start.

Reset
REQ-025 SHALL on rst=0 immediately force IDLE, clear shadow coefficients, counters, checksum and FIFO, and drive all valid/ready/busy/done outputs 0, data outputs 0.
REQ-026 SHALL treat reset mid-run as abort: no done pulse, queued results discarded.

Configuration
REQ-027 SHALL, with FIR_DRIVER_CHECKSUM_EN defined, accumulate checksum += zero-extended res_data on each pop, modulo 2^24, cleared on accepted start.
REQ-028 SHALL, without FIR_DRIVER_CHECKSUM_EN, tie checksum to 0 and instantiate no accumulator.

Structure
REQ-029 SHALL place state encoding typedef, SAMPLE_W=8, RESULT_W=16, IDX_W=3 in shared package fir_pkg.
REQ-030 SHALL implement the result FIFO as sub-module fir_res_fifo.

Verification
REQ-031 SHALL cover: shadow=1,0,0,0,0,0,0, run_len=3, samples 5,6,7, filter model latency 2 -> res 5,6,7, done pulse once, sample_count=3.
REQ-032 SHALL cover: weight_ready low 10 cycles during tap 3 -> weight_idx/weight_data held stable, tap order 0..6 exact.
REQ-033 SHALL cover: res_ready=0, run_len=8 -> at most 4 input handshakes, no output_valid beat dropped; release -> all 8 results in order.
REQ-034 SHALL cover: run_len=0 -> 7 weight beats, zero input handshakes, done after LOAD_W.
REQ-035 SHALL cover: rst=0 after 2 of 5 samples -> all outputs 0 same cycle, state IDLE, no done.
REQ-036 SHALL cover with FIR_DRIVER_CHECKSUM_EN: results 0xFFFF x 300 -> checksum 0x2B_FED4 (300*65535 mod 2^24).
